puf_sequencer: RTL
==================

Name: puf_sequencer

Overview:
- Control FSM for the serialized ring-oscillator PUF datapath: RO bank, challenge scrambler, 8:1 selection muxes, edge counters and the comparison stage.
- Accepts one 8-bit challenge through a valid/ready handshake and loads it into the scrambler.
- For each response bit, runs a settle interval and then a fixed measurement window, with the ROs enabled and the counters running.
- Compares the two selected counts and shifts the result into the response register. After N_BITS evaluations it presents the response through a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 4: cycles with ROs enabled and counters held clear after each selection change. Must be ≥ 1.
- WINDOW_CYCLES, 1024: measurement window length, in clk cycles. Must be ≥ 1.
- CNT_W, 16: width of the external counter values.
- N_BITS, 8: number of response bits per challenge.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- chall_valid, input, 1: challenge offered.
- chall_ready, output, 1: sequencer can accept a challenge.
- chall_in, input, 8: challenge value.
- abort, input, 1: synchronous cancel of the run in progress.
- sel_load, output, 1: one-cycle pulse; scrambler loads chall_reg.
- chall_reg, output, 8: captured challenge, valid while busy.
- sel_step, output, 1: one-cycle pulse; scrambler advances to the next RO pair.
- ro_en, output, 1: enables the RO bank.
- cnt_clr, output, 1: synchronous clear to both edge counters.
- cnt_a, input, CNT_W: count from the first selected RO.
- cnt_b, input, CNT_W: count from the second selected RO.
- response, output, N_BITS: assembled response.
- resp_valid, output, 1: response is complete.
- resp_ready, input, 1: consumer accepts the response.
- tie_seen, output, 1: at least one compare in this run had cnt_a == cnt_b.
- busy, output, 1: FSM is not in IDLE.

Behaviour:
- Reset: rst high asynchronously clears all state. State goes to IDLE; bit_idx, chall_reg, response and tie_seen go to 0. sel_load, sel_step, ro_en, resp_valid and busy go to 0. cnt_clr goes to 1. chall_ready goes to 1 once the FSM is in IDLE.
- IDLE:
  - chall_ready = 1 and cnt_clr = 1.
  - On chall_valid & chall_ready: capture chall_in into chall_reg and go to LOAD.
- LOAD (1 cycle):
  - sel_load = 1 and cnt_clr = 1.
  - Clear response, bit_idx and tie_seen, then go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): ro_en = 1 and cnt_clr = 1; then go to MEASURE.
- MEASURE (WINDOW_CYCLES cycles): ro_en = 1 and cnt_clr = 0; then go to COMPARE.
- COMPARE (1 cycle):
  - ro_en = 0 and cnt_clr = 0; counts are frozen.
  - response[bit_idx] <= (cnt_a > cnt_b), unsigned compare. Bits fill LSB first.
  - If cnt_a == cnt_b: the bit is 0 and tie_seen <= 1 (sticky until the next LOAD).
  - If bit_idx == N_BITS-1, go to DONE; otherwise go to NEXT.
- NEXT (1 cycle): sel_step = 1, cnt_clr = 1, bit_idx++; then go to SETTLE.
- DONE:
  - resp_valid = 1; response and tie_seen are held stable.
  - On resp_ready, go to IDLE. resp_valid drops in the same edge.
- Latency:
  - resp_valid rises exactly 1 + N_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+1) + (N_BITS-1) cycles after the accepting edge.
- Handshake rules:
  - chall_ready = 0 in every state except IDLE; chall_valid is ignored outside IDLE.
  - busy = 1 in every state except IDLE.
  - A new challenge cannot be accepted in the same cycle as the DONE→IDLE transition.
- abort:
  - In any state except IDLE and DONE: next edge goes to IDLE with ro_en = 0, response cleared, resp_valid never asserted.
  - Ignored in IDLE and DONE.
- Simultaneous events:
  - abort and the final COMPARE in the same cycle: abort wins.
  - rst overrides everything.
- Timer:
  - A single down-counter, sized to max(SETTLE_CYCLES, WINDOW_CYCLES), is reloaded on every state entry.
  - No wrap-around is possible.

Decomposition:
- Package puf_ctrl_pkg contains:
  - the state enum: IDLE, LOAD, SETTLE, MEASURE, COMPARE, NEXT, DONE;
  - default parameter constants;
  - a clog2-based timer width function.
- One sub-module: puf_window_timer.
  - Loadable down-counter: inputs load and load_val; output expired.
  - Shared by the SETTLE and MEASURE states.

Test Plan (SETTLE_CYCLES=2, WINDOW_CYCLES=8, N_BITS=8, so latency = 96):
- Basic run: cnt_a=20, cnt_b=10 constant; accept 8'hA5.
  - Expect one sel_load pulse, chall_reg=8'hA5, 7 sel_step pulses.
  - resp_valid exactly 96 cycles after accept, response=8'hFF, tie_seen=0.
- Per-bit pattern: drive cnt_a>cnt_b on bits 1,3,4,6 and cnt_a<cnt_b on the others.
  - Expect response=8'h5A.
- Tie: cnt_a == cnt_b = 7 on bit 3 only, cnt_a > cnt_b elsewhere.
  - Expect response=8'hF7 and tie_seen=1.
  - The next challenge's LOAD clears tie_seen.
- Backpressure: hold resp_ready low for 20 cycles after resp_valid while chall_valid=1 with 8'h3C.
  - resp_valid and response stay stable; chall_ready=0; 8'h3C is not captured.
  - Raise resp_ready: IDLE next cycle, 8'h3C accepted the cycle after.
- Abort: pulse abort during MEASURE of bit 4.
  - Next cycle: IDLE, ro_en=0, busy=0, chall_ready=1, response=0.
  - resp_valid never rises.
- Asynchronous reset: assert rst mid-window, between clock edges.
  - ro_en, busy and resp_valid go to 0 and cnt_clr goes to 1 without waiting for a clk edge.
  - After release, a fresh challenge completes in 96 cycles.

Source files
------------

// File: rtl/puf_ctrl_pkg.sv
// Shared types and helpers for the ring-oscillator PUF sequencer: FSM states,
// default parameter values, timer sizing and the per-state output decode.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        COMPARE = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_WINDOW_CYCLES = 1024;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_N_BITS        = 8;

    // Control strobes that are a pure function of the FSM state.
    typedef struct packed {
        logic chall_ready;
        logic sel_load;
        logic sel_step;
        logic ro_en;
        logic cnt_clr;
        logic resp_valid;
        logic busy;
    } ctrl_out_t;

    // Bits needed to hold values 0..max_count-1, never less than one bit.
    function automatic int timer_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

    function automatic ctrl_out_t decode_outputs(input state_t s);
        ctrl_out_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            IDLE: begin
                o.chall_ready = 1'b1;
                o.cnt_clr     = 1'b1;
            end
            LOAD: begin
                o.sel_load = 1'b1;
                o.cnt_clr  = 1'b1;
            end
            SETTLE: begin
                o.ro_en   = 1'b1;
                o.cnt_clr = 1'b1;
            end
            MEASURE: o.ro_en = 1'b1;
            COMPARE: o.ro_en = 1'b0;
            NEXT: begin
                o.sel_step = 1'b1;
                o.cnt_clr  = 1'b1;
            end
            DONE:    o.resp_valid = 1'b1;
            default: o.cnt_clr = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter shared by the settle and measurement phases.
// Saturates at zero; expired is high while the count is zero.
module puf_window_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/puf_sequencer.sv
// Control FSM for the serialized RO-PUF: takes a challenge, runs settle/measure/
// compare per response bit, and hands the assembled response back via valid/ready.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid holds its payload stable until that edge, ready may toggle freely.
module puf_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int N_BITS        = DEF_N_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chall_valid,
    output logic              chall_ready,
    input  logic [7:0]        chall_in,
    input  logic              abort,
    output logic              sel_load,
    output logic [7:0]        chall_reg,
    output logic              sel_step,
    output logic              ro_en,
    output logic              cnt_clr,
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic [CNT_W-1:0]  cnt_b,
    output logic [N_BITS-1:0] response,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              tie_seen,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int TMR_W   = timer_width(TMR_MAX);
    localparam int IDX_W   = timer_width(N_BITS);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BITS - 1);

    state_t            state_q, state_d;
    logic [7:0]        chall_q, chall_d;
    logic [N_BITS-1:0] resp_q, resp_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tie_q, tie_d;
    ctrl_out_t         out_q;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    always_comb begin
        state_d   = state_q;
        chall_d   = chall_q;
        resp_d    = resp_q;
        bit_idx_d = bit_idx_q;
        tie_d     = tie_q;

        case (state_q)
            IDLE: begin
                if (chall_valid && out_q.chall_ready) begin
                    chall_d = chall_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                resp_d    = '0;
                bit_idx_d = '0;
                tie_d     = 1'b0;
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (tmr_expired) state_d = MEASURE;
            end
            MEASURE: begin
                if (tmr_expired) state_d = COMPARE;
            end
            COMPARE: begin
                // Counts are frozen here; a tie yields 0 and is flagged.
                resp_d[bit_idx_q] = (cnt_a > cnt_b);
                if (cnt_a == cnt_b) tie_d = 1'b1;
                state_d = (bit_idx_q == LAST_IDX) ? DONE : NEXT;
            end
            NEXT: begin
                bit_idx_d = bit_idx_q + 1'b1;
                state_d   = SETTLE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Cancel beats every in-flight transition, including the last compare.
        if (abort && (state_q != IDLE) && (state_q != DONE)) begin
            state_d = IDLE;
            resp_d  = '0;
            tie_d   = tie_q;
        end
    end

    // Reload on every state change so each phase starts with a fresh count.
    assign tmr_load = (state_d != state_q);
    assign tmr_val  = (state_d == MEASURE) ? WINDOW_LD : SETTLE_LD;

    puf_window_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            chall_q   <= '0;
            resp_q    <= '0;
            bit_idx_q <= '0;
            tie_q     <= 1'b0;
            out_q     <= decode_outputs(IDLE);
        end else begin
            state_q   <= state_d;
            chall_q   <= chall_d;
            resp_q    <= resp_d;
            bit_idx_q <= bit_idx_d;
            tie_q     <= tie_d;
            out_q     <= decode_outputs(state_d);
        end
    end

    assign chall_ready = out_q.chall_ready;
    assign sel_load    = out_q.sel_load;
    assign sel_step    = out_q.sel_step;
    assign ro_en       = out_q.ro_en;
    assign cnt_clr     = out_q.cnt_clr;
    assign resp_valid  = out_q.resp_valid;
    assign busy        = out_q.busy;
    assign chall_reg   = chall_q;
    assign response    = resp_q;
    assign tie_seen    = tie_q;
    assign dbg_state   = state_q;

endmodule
